// File: rtl/nat_pkg.sv
// Shared types, parser constants and hash for the NAT connection table.
package nat_pkg;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [7:0]  proto;
  } tuple_t;

  localparam logic [2:0] ETH_BEAT   = 3'd1;
  localparam logic [2:0] PROTO_BEAT = 3'd2;
  localparam logic [2:0] IP_BEAT    = 3'd3;
  localparam logic [2:0] PORT_BEAT  = 3'd4;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;

  function automatic logic [31:0] nat_hash(input tuple_t t);
    return t.src_ip ^ t.dst_ip ^ {16'h0, t.src_port} ^ {16'h0, t.dst_port} ^ {24'h0, t.proto};
  endfunction

endpackage

// File: rtl/nat_conn_table_conn_ram.sv
// Simple dual-port connection RAM with a registered (1-cycle) read port.
module conn_ram #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 105
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/nat_conn_table.sv
// NAT connection tracker: parses the IPv4 5-tuple, looks it up in a linearly probed
// hash table and rewrites the L4 source port of beat 4 with the table index.
module nat_conn_table
  import nat_pkg::*;
#(
  parameter int unsigned HASH_W    = 16,
  parameter int unsigned MAX_PROBE = 16,
  parameter bit          FULL_MARK = 1'b1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      s_axis_tdata,
  input  logic [7:0]       s_axis_tkeep,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tuser,
  output logic             s_axis_tready,
  output logic [63:0]      m_axis_tdata,
  output logic [7:0]       m_axis_tkeep,
  output logic             m_axis_tlast,
  output logic             m_axis_tvalid,
  output logic             m_axis_tuser,
  input  logic             m_axis_tready,
  input  logic             clear_tbl,
  output logic             init_busy,
  output logic [CNT_W-1:0] stat_new,
  output logic [CNT_W-1:0] stat_hit,
  output logic [CNT_W-1:0] stat_full
);

  localparam int unsigned     ENTRY_W    = $bits(tuple_t) + 1;
  localparam logic [HASH_W:0] PROBE_LAST = (HASH_W + 1)'(MAX_PROBE - 1);
  localparam logic [2:0]      BEAT_SAT   = 3'd5;

  localparam logic [2:0] StInit = 3'd0;
  localparam logic [2:0] StPass = 3'd1;
  localparam logic [2:0] StRd   = 3'd2;
  localparam logic [2:0] StCmp  = 3'd3;
  localparam logic [2:0] StEmit = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [HASH_W-1:0]  sweep_q, probe_addr_q, cur_hash, ram_waddr;
  logic [HASH_W:0]    probe_cnt_q;
  logic [2:0]         beat_q;
  logic               is_ip_q, full_q, clear_q;
  logic [7:0]         proto_q;
  logic [31:0]        src_ip_q;
  logic [15:0]        dst_lo_q;
  tuple_t             key_q, cur_key, rd_key;
  logic [63:0]        hold_data_q, m_data_q, ld_data;
  logic [7:0]         hold_keep_q, m_keep_q, ld_keep;
  logic               hold_last_q, hold_user_q, m_last_q, m_user_q, m_valid_q, ld_last, ld_user;
  logic [CNT_W-1:0]   new_q, hit_q, fcnt_q;
  logic [ENTRY_W-1:0] rd_entry, ram_wdata;
  logic               ram_we, out_free, clear_go, accept, capture, load_pass, emit_go;
  logic               lk_hit, lk_empty, lk_full;

  conn_ram #(
    .ADDR_W(HASH_W),
    .DATA_W(ENTRY_W)
  ) u_conn_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(probe_addr_q),
    .rdata(rd_entry)
  );

  always_comb begin
    out_free      = !m_valid_q || m_axis_tready;
    // A pending clear waits for a packet boundary with nothing left in the output register.
    clear_go      = (state_q == StPass) && clear_q && (beat_q == 3'd0) && !m_valid_q;
    s_axis_tready = (state_q == StPass) && out_free && !clear_go;
    accept        = s_axis_tvalid && s_axis_tready;
    capture       = accept && is_ip_q && (beat_q == PORT_BEAT);
    load_pass     = accept && !capture;
    emit_go       = (state_q == StEmit) && out_free;

    cur_key.src_ip   = src_ip_q;
    cur_key.dst_ip   = {s_axis_tdata[15:0], dst_lo_q};
    cur_key.src_port = s_axis_tdata[31:16];
    cur_key.dst_port = s_axis_tdata[47:32];
    cur_key.proto    = proto_q;
    cur_hash         = HASH_W'(nat_hash(cur_key));

    rd_key   = tuple_t'(rd_entry[ENTRY_W-2:0]);
    lk_hit   = (state_q == StCmp) && rd_entry[ENTRY_W-1] && (rd_key == key_q);
    lk_empty = (state_q == StCmp) && !rd_entry[ENTRY_W-1];
    lk_full  = (state_q == StCmp) && rd_entry[ENTRY_W-1] && (rd_key != key_q)
               && (probe_cnt_q == PROBE_LAST);

    ld_data = emit_go ? hold_data_q : s_axis_tdata;
    ld_keep = emit_go ? hold_keep_q : s_axis_tkeep;
    ld_last = emit_go ? hold_last_q : s_axis_tlast;
    ld_user = emit_go ? hold_user_q : s_axis_tuser;

    ram_we    = (state_q == StInit) || lk_empty;
    ram_waddr = (state_q == StInit) ? sweep_q : probe_addr_q;
    ram_wdata = (state_q == StInit) ? '0 : {1'b1, key_q};

    state_d = state_q;
    case (state_q)
      StInit:  if (&sweep_q) state_d = StPass;
      StPass:  if (clear_go) state_d = StInit; else if (capture) state_d = StRd;
      StRd:    state_d = StCmp;
      StCmp:   state_d = (lk_hit || lk_empty || lk_full) ? StEmit : StRd;
      StEmit:  if (emit_go) state_d = StPass;
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StInit;
      sweep_q      <= '0;
      probe_addr_q <= '0;
      probe_cnt_q  <= '0;
      beat_q       <= '0;
      is_ip_q      <= 1'b0;
      full_q       <= 1'b0;
      clear_q      <= 1'b0;
      proto_q      <= '0;
      src_ip_q     <= '0;
      dst_lo_q     <= '0;
      key_q        <= '0;
      hold_data_q  <= '0;
      hold_keep_q  <= '0;
      hold_last_q  <= 1'b0;
      hold_user_q  <= 1'b0;
      m_data_q     <= '0;
      m_keep_q     <= '0;
      m_last_q     <= 1'b0;
      m_user_q     <= 1'b0;
      m_valid_q    <= 1'b0;
      new_q        <= '0;
      hit_q        <= '0;
      fcnt_q       <= '0;
    end else begin
      state_q <= state_d;
      clear_q <= clear_tbl || (clear_q && !clear_go);
      if (clear_go) sweep_q <= '0;
      else if (state_q == StInit) sweep_q <= sweep_q + 1'b1;

      if (accept) begin
        beat_q <= s_axis_tlast ? 3'd0 : ((beat_q == BEAT_SAT) ? beat_q : beat_q + 1'b1);
        if (beat_q == ETH_BEAT) begin
          is_ip_q <= (s_axis_tdata[39:32] == ETHERTYPE_IPV4[15:8])
                     && (s_axis_tdata[47:40] == ETHERTYPE_IPV4[7:0]);
        end
        if (beat_q == PROTO_BEAT) proto_q <= s_axis_tdata[63:56];
        if (beat_q == IP_BEAT) begin
          src_ip_q <= s_axis_tdata[47:16];
          dst_lo_q <= s_axis_tdata[63:48];
        end
      end

      if (capture) begin
        key_q        <= cur_key;
        probe_addr_q <= cur_hash;
        probe_cnt_q  <= '0;
        hold_data_q  <= s_axis_tdata;
        hold_keep_q  <= s_axis_tkeep;
        hold_last_q  <= s_axis_tlast;
        hold_user_q  <= s_axis_tuser;
      end else if ((state_q == StCmp) && !lk_hit && !lk_empty && !lk_full) begin
        probe_cnt_q  <= probe_cnt_q + 1'b1;
        probe_addr_q <= probe_addr_q + 1'b1;
      end
      if (lk_hit || lk_empty) hold_data_q[31:16] <= 16'(probe_addr_q);

      if (lk_full) full_q <= 1'b1;
      else if ((emit_go || load_pass) && ld_last) full_q <= 1'b0;

      if (emit_go || load_pass) begin
        m_valid_q <= 1'b1;
        m_data_q  <= ld_data;
        m_keep_q  <= ld_keep;
        m_last_q  <= ld_last;
        m_user_q  <= ld_user | (FULL_MARK && full_q && ld_last);
      end else if (m_axis_tready) begin
        m_valid_q <= 1'b0;
      end

      if (lk_empty && (new_q != '1)) new_q <= new_q + 1'b1;
      if (lk_hit && (hit_q != '1)) hit_q <= hit_q + 1'b1;
      if (lk_full && (fcnt_q != '1)) fcnt_q <= fcnt_q + 1'b1;
    end
  end

  assign init_busy     = rst_n && (state_q == StInit);
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tuser  = m_user_q;
  assign m_axis_tvalid = m_valid_q;
  assign stat_new      = new_q;
  assign stat_hit      = hit_q;
  assign stat_full     = fcnt_q;

endmodule

// File: doc/nat_conn_table.md
Name: nat_conn_table

Overview:
- Parametrised successor of the single-table NAT connection tracker on the 64-bit AXI-Stream packet path.
- Parses Ethernet/IPv4 5-tuple, looks up/inserts it in a hashed table with bounded linear probing, and rewrites the L4 source-port field with the table index.
- New versus the previous generation:
  - full downstream backpressure;
  - synchronous-read table (BRAM-friendly);
  - reset/clear init sweep;
  - bounded probe with table-full handling;
  - statistics counters.

Parameters:
- HASH_W, 16, table index width; DEPTH = 2**HASH_W entries; legal range 4..16.
- MAX_PROBE, 16, maximum entries examined per lookup before declaring the table full; 1..DEPTH.
- FULL_MARK, 1, on table-full: 1 = assert m_axis_tuser on the packet's tlast beat; 0 = pass unmarked.
- CNT_W, 32, statistics counter width.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- s_axis_tdata  in  64  ingress data.
- s_axis_tkeep  in  8  ingress byte enables, passed through.
- s_axis_tlast  in  1  ingress end of packet.
- s_axis_tvalid  in  1  ingress valid.
- s_axis_tuser  in  1  ingress error flag, passed through (OR-ed with full mark).
- s_axis_tready  out  1  ingress ready.
- m_axis_tdata  out  64  egress data.
- m_axis_tkeep  out  8  egress byte enables.
- m_axis_tlast  out  1  egress end of packet.
- m_axis_tvalid  out  1  egress valid.
- m_axis_tuser  out  1  egress error flag.
- m_axis_tready  in  1  egress ready.
- clear_tbl  in  1  pulse; invalidates the whole table at the next packet boundary.
- init_busy  out  1  high while the invalidation sweep runs.
- stat_new  out  CNT_W  count of inserted connections.
- stat_hit  out  CNT_W  count of lookups matching an existing entry.
- stat_full  out  CNT_W  count of lookups that hit MAX_PROBE.

Behaviour:
Reset values:
- rst_n low: all outputs 0, beat counter 0, state INIT, sweep address 0.
- Table RAM contents are not reset; the INIT sweep invalidates them.

Entry format and hash:
- Entry = {valid, src_ip[31:0], dst_ip[31:0], src_port[15:0], dst_port[15:0], proto[7:0]}.
- hash = (src_ip ^ dst_ip ^ src_port ^ dst_port ^ proto), each operand zero-extended to 32 bits, then take [HASH_W-1:0].

States:
- INIT:
  - Writes valid=0 to address sweep_addr each cycle, DEPTH cycles total; s_axis_tready=0; init_busy=1.
  - Then go to PASS.
- PASS:
  - s_axis_tready = !m_axis_tvalid || m_axis_tready.
  - Accepted beat is registered to the m_axis side; latency 1 cycle.
  - Beat counter increments per accepted beat and resets on tlast.
- Parsing per beat index (beats numbered from 0):
  - Beat 1: is_ip = (tdata[39:32]==8'h08 && tdata[47:40]==8'h00).
  - Beat 2: proto = tdata[63:56].
  - Beat 3: src_ip = tdata[47:16]; dst_ip[15:0] = tdata[63:48].
  - Beat 4: dst_ip[31:16] = tdata[15:0]; src_port = tdata[31:16]; dst_port = tdata[47:32].
- Beat 4 with is_ip:
  - The beat is captured into a hold register, not presented downstream.
  - s_axis_tready=0; probe_addr=hash; probe_cnt=0; go to RD.
- RD: issue RAM read at probe_addr; go to CMP next cycle.
- CMP (RAM data valid this cycle):
  - Match (valid && key equal): stat_hit++; go to EMIT with rewrite.
  - Empty (!valid): write {1,key} at probe_addr; stat_new++; go to EMIT with rewrite.
  - Otherwise: probe_cnt++.
    - If probe_cnt+1 == MAX_PROBE: stat_full++; set full_flag; go to EMIT without rewrite.
    - Else probe_addr = (probe_addr+1) mod DEPTH (wraps DEPTH-1 to 0); go to RD.
- Rewrite: held tdata[31:16] = {zero-extend to 16 bits, probe_addr}; all other fields unchanged.
- EMIT:
  - Present the held beat when the output register is free: m_axis_tvalid=1, held beat stays until m_axis_tready.
  - Then return to PASS.
- Full flag:
  - Stays set until the packet's tlast beat is emitted.
  - With FULL_MARK=1, that beat carries m_axis_tuser=1.

Boundary conditions:
- Non-IP packets and packets ending before beat 4: pure pass-through; no lookup; no counter change.
- tlast on beat 4 itself: lookup completes, then beat emitted with tlast=1, and parser state resets.
- Backpressure: m_axis_tvalid and data held stable while m_axis_tready=0; no beat is lost or duplicated.
- clear_tbl:
  - Latched.
  - Honoured only in PASS with beat counter 0 and output register empty.
  - Then enters INIT; a clear during a packet is deferred.
- Probe latency: 2 cycles per probe; worst case 2*MAX_PROBE+1 stall cycles per packet.
- rst_n asserted mid-probe: immediate return to reset values; the in-flight packet is discarded; INIT re-runs after release.
- Counters saturate at all-ones.

Decomposition:
- Shared package nat_pkg:
  - tuple_t struct (src_ip, dst_ip, src_port, dst_port, proto);
  - beat-index constants (ETH_BEAT=1, PROTO_BEAT=2, IP_BEAT=3, PORT_BEAT=4);
  - ETHERTYPE_IPV4 = 16'h0800;
  - hash function nat_hash.
- One sub-module conn_ram: simple dual-port RAM, DEPTH x 105 bits, 1-cycle synchronous read, write-first not required.

Test Plan:
- Reset release with HASH_W=4: init_busy high exactly 16 cycles, s_axis_tready low throughout, then high.
- IPv4 packet src_ip=10.0.0.1, dst_ip=8.8.8.8, sport=1234, dport=80, proto=6, 8 beats, m_axis_tready=1:
  - beat 4 emitted with tdata[31:16] = hash value;
  - stat_new=1;
  - all other beats bit-identical.
- Same packet repeated: same rewrite index, stat_hit=1, stat_new unchanged.
- Two tuples with identical hash, HASH_W=4: second tuple rewritten to hash+1; a tuple hashing to 15 with entry 15 occupied gets index 0 (wrap).
- MAX_PROBE=2 with hash, hash+1 occupied by other tuples:
  - packet passes unmodified;
  - stat_full=1;
  - tlast beat carries m_axis_tuser=1.
- Random m_axis_tready (50%) with mixed ARP/IPv4/4-beat runt packets: output stream equals reference model; runts and ARP unmodified.
- clear_tbl pulsed mid-packet: sweep starts only after tlast; afterwards the previously seen tuple counts as stat_new.
